// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_ALIGN_CHK_EN (see mem_arbiter.sv).
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 4;
    localparam int P_IFETCH   = 0;
    localparam int P_DATA     = 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr.sv
// rr_arbiter2: two-way round-robin picker with a last-grant pointer.
// The pointer resets as if port 1 went last, so port 0 wins the first tie.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       en_i,
    output logic [1:0] gnt_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            unique case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
                default: gnt_o = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (en_i && |req_i) last_d = gnt_o[P_DATA];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= 1'(P_DATA);
        else        last_q <= last_d;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared word memory.
// Define MEM_ARB_ALIGN_CHK_EN to add p0_err/p1_err misalignment reporting.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int ACCESS_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p1_req,
    input  logic              p0_we,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_done,
    output logic              p1_done,
    output logic [DATA_W-1:0] p0_rdata,
    output logic [DATA_W-1:0] p1_rdata,
`ifdef MEM_ARB_ALIGN_CHK_EN
    output logic              p0_err,
    output logic              p1_err,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   win_q, we_q, skip_q;
    logic [ADDR_W-3:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [1:0][DATA_W-1:0] rdata_q;

    logic [1:0]        req, gnt;
    logic              arb_en, start, last;
    logic              sel, sel_we, sel_skip;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    assign req    = {p1_req, p0_req};
    assign arb_en = (state_q == IDLE);
    assign start  = arb_en && |req;
    assign last   = (state_q == ACCESS) && (cnt_q == '0);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .rst_n (rst_n),
        .req_i (req),
        .en_i  (arb_en),
        .gnt_o (gnt)
    );

    assign sel       = gnt[P_DATA];
    assign sel_we    = sel ? p1_we    : p0_we;
    assign sel_addr  = sel ? p1_addr  : p0_addr;
    assign sel_wdata = sel ? p1_wdata : p0_wdata;

`ifdef MEM_ARB_ALIGN_CHK_EN
    assign sel_skip = (sel_addr[1:0] != 2'b00);
`else
    logic unused_lsb;
    assign sel_skip   = 1'b0;
    assign unused_lsb = ^sel_addr[1:0];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCESS;
                    cnt_d   = CNT_W'(ACCESS_CYCLES - 1);
                end
            end
            ACCESS: begin
                if (cnt_q == '0) state_d = DONE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        p0_gnt    = (state_q != IDLE) && !win_q;
        p1_gnt    = (state_q != IDLE) &&  win_q;
        p0_done   = (state_q == DONE) && !win_q;
        p1_done   = (state_q == DONE) &&  win_q;
        mem_read  = (state_q == ACCESS) && !we_q && !skip_q;
        mem_write = last && we_q && !skip_q;
        mem_addr  = {addr_q, 2'b00};
        mem_wdata = wdata_q;
        p0_rdata  = rdata_q[P_IFETCH];
        p1_rdata  = rdata_q[P_DATA];
    end

    // Request fields are latched at grant so a port may drop req mid-access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q   <= 1'b0;
            we_q    <= 1'b0;
            skip_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (start) begin
                win_q   <= sel;
                we_q    <= sel_we;
                skip_q  <= sel_skip;
                addr_q  <= sel_addr[ADDR_W-1:2];
                wdata_q <= sel_wdata;
            end
            if (last && !we_q && !skip_q) rdata_q[win_q] <= mem_rdata;
        end
    end

`ifdef MEM_ARB_ALIGN_CHK_EN
    logic [1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    err_q        <= '0;
        else if (last) err_q[win_q] <= skip_q;
    end

    assign p0_err = err_q[P_IFETCH];
    assign p1_err = err_q[P_DATA];
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a behavioural word memory.
// Build with MEM_ARB_ALIGN_CHK_EN defined to exercise the err outputs.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int AC = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          p0_req, p1_req, p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_done, p1_done;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write;
`ifdef MEM_ARB_ALIGN_CHK_EN
    logic          p0_err, p1_err;
    logic [1:0]    exp_err;
`endif

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p1_req    (p1_req),
        .p0_we     (p0_we),
        .p1_we     (p1_we),
        .p0_addr   (p0_addr),
        .p1_addr   (p1_addr),
        .p0_wdata  (p0_wdata),
        .p1_wdata  (p1_wdata),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_done   (p0_done),
        .p1_done   (p1_done),
        .p0_rdata  (p0_rdata),
        .p1_rdata  (p1_rdata),
`ifdef MEM_ARB_ALIGN_CHK_EN
        .p0_err    (p0_err),
        .p1_err    (p1_err),
`endif
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    // Word memory; a non-aligned address returns a poison pattern.
    logic [31:0] mem [0:63];
    assign mem_rdata = (mem_addr[1:0] == 2'b00) ? mem[mem_addr[7:2]] : 32'hBADBAD00;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(posedge clk);
            if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        bit          err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdp = 0;
    int wrp = 0;
    logic [1:0][31:0] exp_rd;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_port(input bit p, input bit rq, input bit we,
                            input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            p1_req = rq; p1_we = we; p1_addr = a; p1_wdata = wd;
        end else begin
            p0_req = rq; p0_we = we; p0_addr = a; p0_wdata = wd;
        end
    endtask

    task automatic push(input bit p, input bit we, input bit err,
                        input logic [31:0] d, input int c);
        exp_t e;
        e.port = p; e.we = we; e.err = err; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    // Call at a negedge while the FSM is idle.
    task automatic issue(input bit p, input bit we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] d, input bit err);
        set_port(p, 1'b1, we, a, wd);
        push(p, we, err, d, cyc + 1 + AC);
    endtask

    task automatic wait_done(input bit p);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = p ? p1_done : p0_done;
        end
        chk(p ? "p1_done_seen" : "p0_done_seen", 32'(seen), 32'd1);
        set_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic txn(input bit p, input bit we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] d, input bit err);
        @(negedge clk);
        issue(p, we, a, wd, d, err);
        wait_done(p);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            rdp = 0;
            wrp = 0;
            exp_rd = '0;
`ifdef MEM_ARB_ALIGN_CHK_EN
            exp_err = '0;
`endif
        end else begin
            rdp += int'(mem_read);
            wrp += int'(mem_write);
            chk("gnt_onehot", 32'(p0_gnt & p1_gnt), 32'd0);
            if (p0_done || p1_done) begin
                if (p0_done && p1_done) begin
                    chk("done_onehot", 32'd1, 32'd0);
                end else if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: port %0d done with nothing outstanding", p1_done);
                end else begin
                    e = sb.pop_front();
                    chk("done_port", 32'(p1_done), 32'(e.port));
                    chk("done_cycle", cyc, e.cyc);
                    chk("gnt_in_done", {30'b0, p1_gnt, p0_gnt}, e.port ? 32'd2 : 32'd1);
                    chk("rd_pulses", rdp, (e.we || e.err) ? 0 : AC);
                    chk("wr_pulses", wrp, (e.we && !e.err) ? 1 : 0);
                    if (!e.we && !e.err) exp_rd[e.port] = e.data;
                    chk("p0_rdata", p0_rdata, exp_rd[0]);
                    chk("p1_rdata", p1_rdata, exp_rd[1]);
`ifdef MEM_ARB_ALIGN_CHK_EN
                    exp_err[e.port] = e.err;
                    chk("err", {30'b0, p1_err, p0_err}, {30'b0, exp_err});
`endif
                end
                rdp = 0;
                wrp = 0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int n;
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        chk("rst_ctl", {26'b0, p0_gnt, p1_gnt, p0_done, p1_done, mem_read, mem_write}, 32'd0);
        chk("rst_rdata", p0_rdata | p1_rdata, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        rst_n = 1'b1;

        // Tie straight out of reset: port 0 first, then port 1.
        @(negedge clk);
        c = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'd0, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'd4, '0);
        push(1'b0, 1'b0, 1'b0, 32'd0, c + 1 + AC);
        push(1'b1, 1'b0, 1'b0, 32'd0, c + 3 + 2 * AC);
        wait_done(1'b0);
        wait_done(1'b1);

        // Data-port writes and readbacks, including an unwritten word.
        txn(1'b1, 1'b1, 32'd16, 32'h12345678, '0, 1'b0);
        txn(1'b1, 1'b1, 32'd24, 32'h89abcdef, '0, 1'b0);
        txn(1'b1, 1'b0, 32'd16, '0, 32'h12345678, 1'b0);
        txn(1'b1, 1'b0, 32'd20, '0, 32'h00000000, 1'b0);
        txn(1'b1, 1'b0, 32'd24, '0, 32'h89abcdef, 1'b0);

        // Both ports streaming: strict alternation starting with port 0.
        @(negedge clk);
        c = cyc;
        set_port(1'b0, 1'b1, 1'b0, 32'd16, '0);
        set_port(1'b1, 1'b1, 1'b0, 32'd16, '0);
        for (int i = 0; i < 6; i++)
            push(1'(i % 2), 1'b0, 1'b0, 32'h12345678, c + 1 + AC + i * (AC + 2));
        n = 0;
        for (int i = 0; i < 200 && n < 6; i++) begin
            @(negedge clk);
            if (p0_done || p1_done) n++;
        end
        chk("alt_count", n, 6);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);

        // Multi-cycle write: single write edge, then readback.
        txn(1'b0, 1'b1, 32'd8, 32'hA5A5A5A5, '0, 1'b0);
        txn(1'b0, 1'b0, 32'd8, '0, 32'hA5A5A5A5, 1'b0);

        // Reset in the final access cycle of a write.
        @(negedge clk);
        set_port(1'b1, 1'b1, 1'b1, 32'd32, 32'hDEADBEEF);
        repeat (3) @(negedge clk);
        chk("pre_rst_write", 32'(mem_write), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_ctl", {26'b0, p0_gnt, p1_gnt, p0_done, p1_done, mem_read, mem_write}, 32'd0);
        chk("async_rst_data", p0_rdata | p1_rdata | mem_addr | mem_wdata, 32'd0);
        set_port(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        rst_n = 1'b1;
        chk("mem32_untouched", mem[8], 32'd0);
        txn(1'b0, 1'b0, 32'd32, '0, 32'd0, 1'b0);

        // Misaligned read.
`ifdef MEM_ARB_ALIGN_CHK_EN
        txn(1'b1, 1'b0, 32'd18, '0, '0, 1'b1);
        txn(1'b1, 1'b0, 32'd16, '0, 32'h12345678, 1'b0);
`else
        txn(1'b1, 1'b0, 32'd18, '0, 32'h12345678, 1'b0);
`endif

        // Requester drops req after one access cycle.
        @(negedge clk);
        issue(1'b0, 1'b1, 32'd40, 32'h00000001, '0, 1'b0);
        @(negedge clk);
        set_port(1'b0, 1'b0, 1'b0, '0, '0);
        wait_done(1'b0);
        chk("mem40", mem[10], 32'h00000001);
        txn(1'b0, 1'b0, 32'd40, '0, 32'h00000001, 1'b0);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
